// File: rtl/stream_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_arbiter_pkg
// Description : Shared definitions for the stream round-robin arbiter:
//               FSM state encoding and a constant clog2 helper.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_arbiter_pkg;

    // Arbiter FSM state encoding
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCEPT = 2'd1;
    localparam logic [1:0] SEND   = 2'd2;

    // Ceiling log2, usable in constant expressions (clog2(1) = 0)
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >>> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_round_robin_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Finds the first asserted
//               request strictly after last_grant, wrapping modulo INPUTS.
//               Implemented as rotate -> priority encode -> un-rotate.
// Ports       : req        in  INPUTS     request vector
//               last_grant in  IDX_WIDTH  most recently served index
//               found      out 1          at least one request present
//               index      out IDX_WIDTH  winning index (valid when found)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import stream_arbiter_pkg::*;
#(
    parameter int INPUTS    = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [INPUTS-1:0]    req,
    input  logic [IDX_WIDTH-1:0] last_grant,
    output logic                 found,
    output logic [IDX_WIDTH-1:0] index
);

    logic [2*INPUTS-1:0] doubled;
    logic [INPUTS-1:0]   rotated;
    int                  start_idx;
    int                  offset;
    int                  win_idx;

    always_comb begin
        // Search starts one past the last winner; INPUTS-1 wraps to 0
        start_idx = int'(last_grant) + 1;
        if (start_idx >= INPUTS) begin
            start_idx = 0;
        end

        // Concatenating the vector with itself turns the rotation into a
        // plain right shift; bit 0 of rotated is the highest-priority slot.
        doubled = {req, req};
        rotated = INPUTS'(doubled >> start_idx);

        found  = 1'b0;
        offset = 0;
        for (int k = INPUTS - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                found  = 1'b1;
                offset = k;
            end
        end

        win_idx = start_idx + offset;
        if (win_idx >= INPUTS) begin
            win_idx = win_idx - INPUTS;
        end
        index = IDX_WIDTH'(win_idx);
    end

endmodule
`default_nettype wire

// File: rtl/stream_round_robin_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : stream_round_robin_arbiter
// Description : Shares one stb/ack output stream between INPUTS requesting
//               sources using fair round-robin selection, with optional
//               bounded bursts (MAX_BURST words) per grant. Each output word
//               carries the index of its source in output_z_tag.
// Ports       : clk          in  1             rising-edge clock
//               rst          in  1             async active-high reset
//               inputs       in  INPUTS*WIDTH  packed source data
//               inputs_stb   in  INPUTS        per-source valid
//               inputs_ack   out INPUTS        per-source accept (registered)
//               output_z     out WIDTH         arbitrated data (registered)
//               output_z_tag out TAG_WIDTH     source index of output_z
//               output_z_stb out 1             output valid
//               output_z_ack in  1             consumer accept
// Revision    : 1.0 - initial release
// ============================================================================
module stream_round_robin_arbiter
    import stream_arbiter_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int INPUTS    = 4,
    parameter int TAG_WIDTH = 2,
    parameter int MAX_BURST = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [INPUTS*WIDTH-1:0] inputs,
    input  logic [INPUTS-1:0]       inputs_stb,
    output logic [INPUTS-1:0]       inputs_ack,
    output logic [WIDTH-1:0]        output_z,
    output logic [TAG_WIDTH-1:0]    output_z_tag,
    output logic                    output_z_stb,
    input  logic                    output_z_ack
);

    localparam logic [TAG_WIDTH-1:0] LAST_GRANT_RESET = TAG_WIDTH'(INPUTS - 1);
    localparam logic [8:0]           BURST_LIMIT      = 9'(MAX_BURST);

    if ((TAG_WIDTH < clog2(INPUTS)) || (INPUTS < 2) || (INPUTS > 16) ||
        (MAX_BURST < 1) || (MAX_BURST > 255)) begin : g_param_check
        $error("stream_round_robin_arbiter: illegal parameter combination");
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    logic [1:0]           state;
    logic [1:0]           state_next;
    logic [TAG_WIDTH-1:0] grant;
    logic [TAG_WIDTH-1:0] grant_next;
    logic [TAG_WIDTH-1:0] last_grant;
    logic [TAG_WIDTH-1:0] last_grant_next;
    logic [7:0]           burst_cnt;
    logic [7:0]           burst_cnt_next;
    logic [INPUTS-1:0]    ack_next;
    logic [WIDTH-1:0]     z_next;
    logic [TAG_WIDTH-1:0] tag_next;
    logic                 stb_next;

    // ------------------------------------------------------------------
    // Source data unpacking and derived conditions
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]     source_data [INPUTS];
    logic                 granted_stb;
    logic                 burst_more;
    logic                 pick_found;
    logic [TAG_WIDTH-1:0] pick_index;
    logic [INPUTS-1:0]    pick_onehot;
    logic [INPUTS-1:0]    grant_onehot;

    for (genvar i = 0; i < INPUTS; i++) begin : g_unpack
        assign source_data[i] = inputs[i*WIDTH +: WIDTH];
    end

    assign granted_stb  = inputs_stb[grant];
    // Another word may follow from the same winner only while the count of
    // words already sent in this grant, plus the one just sent, is below MAX_BURST.
    assign burst_more   = (({1'b0, burst_cnt} + 9'd1) < BURST_LIMIT);
    assign pick_onehot  = INPUTS'(1) << pick_index;
    assign grant_onehot = INPUTS'(1) << grant;

    rr_pick #(
        .INPUTS    (INPUTS),
        .IDX_WIDTH (TAG_WIDTH)
    ) u_rr_pick (
        .req        (inputs_stb),
        .last_grant (last_grant),
        .found      (pick_found),
        .index      (pick_index)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            grant        <= '0;
            last_grant   <= LAST_GRANT_RESET;
            burst_cnt    <= '0;
            inputs_ack   <= '0;
            output_z     <= '0;
            output_z_tag <= '0;
            output_z_stb <= 1'b0;
        end else begin
            state        <= state_next;
            grant        <= grant_next;
            last_grant   <= last_grant_next;
            burst_cnt    <= burst_cnt_next;
            inputs_ack   <= ack_next;
            output_z     <= z_next;
            output_z_tag <= tag_next;
            output_z_stb <= stb_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_next = ACCEPT;
                end
            end
            ACCEPT: begin
                if (granted_stb) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (output_z_ack) begin
                    state_next = (burst_more && granted_stb) ? ACCEPT : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        grant_next      = grant;
        last_grant_next = last_grant;
        burst_cnt_next  = burst_cnt;
        ack_next        = inputs_ack;
        z_next          = output_z;
        tag_next        = output_z_tag;
        stb_next        = output_z_stb;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_next = pick_index;
                    ack_next   = pick_onehot;
                end
            end
            ACCEPT: begin
                // ack is already high here, so stb alone completes the transfer
                if (granted_stb) begin
                    z_next   = source_data[grant];
                    tag_next = grant;
                    ack_next = '0;
                    stb_next = 1'b1;
                end
            end
            SEND: begin
                if (output_z_ack) begin
                    stb_next = 1'b0;
                    if (burst_more && granted_stb) begin
                        burst_cnt_next = burst_cnt + 8'd1;
                        ack_next       = grant_onehot;
                    end else begin
                        last_grant_next = grant;
                        burst_cnt_next  = '0;
                    end
                end
            end
            default: begin
                ack_next = '0;
                stb_next = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_round_robin_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_round_robin_arbiter
// Description : Self-checking bench. Two arbiters (MAX_BURST=1 and 2) run the
//               same directed source programs side by side. A word-level
//               model (round-robin pointer, burst count, pending word) is
//               checked every cycle; literal expectations pin tag orders,
//               cycle spacing and reset values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_round_robin_arbiter;

    localparam int WIDTH     = 16;
    localparam int INPUTS    = 4;
    localparam int TAG_WIDTH = 2;
    localparam int NDUT      = 2;
    localparam int LOGSZ     = 32;

    logic                    clk;
    logic                    rst;
    logic [INPUTS*WIDTH-1:0] inputs       [NDUT];
    logic [INPUTS-1:0]       inputs_stb   [NDUT];
    logic [INPUTS-1:0]       inputs_ack   [NDUT];
    logic [WIDTH-1:0]        output_z     [NDUT];
    logic [TAG_WIDTH-1:0]    output_z_tag [NDUT];
    logic                    output_z_stb [NDUT];
    logic                    output_z_ack [NDUT];

    stream_round_robin_arbiter #(
        .WIDTH(WIDTH), .INPUTS(INPUTS), .TAG_WIDTH(TAG_WIDTH), .MAX_BURST(1)
    ) u_dut_rr (
        .clk(clk), .rst(rst),
        .inputs(inputs[0]), .inputs_stb(inputs_stb[0]), .inputs_ack(inputs_ack[0]),
        .output_z(output_z[0]), .output_z_tag(output_z_tag[0]),
        .output_z_stb(output_z_stb[0]), .output_z_ack(output_z_ack[0])
    );

    stream_round_robin_arbiter #(
        .WIDTH(WIDTH), .INPUTS(INPUTS), .TAG_WIDTH(TAG_WIDTH), .MAX_BURST(2)
    ) u_dut_burst (
        .clk(clk), .rst(rst),
        .inputs(inputs[1]), .inputs_stb(inputs_stb[1]), .inputs_ack(inputs_ack[1]),
        .output_z(output_z[1]), .output_z_tag(output_z_tag[1]),
        .output_z_stb(output_z_stb[1]), .output_z_ack(output_z_ack[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source programs: words still to deliver and current data per source
    int           remaining [NDUT][INPUTS];
    logic [15:0]  sdata     [NDUT][INPUTS];
    logic         ack_en;

    // Values seen at the last negedge == values present at the following posedge
    logic [3:0]   cap_ack   [NDUT];
    logic [3:0]   cap_stb   [NDUT];
    logic [63:0]  cap_in    [NDUT];
    logic         cap_ozstb [NDUT];
    logic         cap_ozack [NDUT];
    logic [15:0]  cap_oz    [NDUT];
    logic [1:0]   cap_tag   [NDUT];

    // Word-level arbiter model
    bit           busy      [NDUT];
    int           gr        [NDUT];
    int           last      [NDUT];
    int           wcnt      [NDUT];
    bit           pend      [NDUT];
    int           pend_tag  [NDUT];
    logic [15:0]  pend_data [NDUT];

    // Delivery log
    int           log_tag   [NDUT][LOGSZ];
    logic [15:0]  log_data  [NDUT][LOGSZ];
    int           log_cyc   [NDUT][LOGSZ];
    int           nlog      [NDUT];
    logic [3:0]   first_ack [NDUT];
    int           cyc;

    int n_assert;
    int n_fail;

    function automatic int max_burst(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    // First requester strictly after lst, wrapping
    function automatic int pick(input logic [3:0] r, input int lst);
        for (int k = 1; k <= INPUTS; k++) begin
            int idx;
            idx = (lst + k) % INPUTS;
            if (((r >> idx) & 4'd1) != 4'd0) return idx;
        end
        return -1;
    endfunction

    function automatic logic [31:0] pack(input logic s, input logic [3:0] a,
                                         input logic [1:0] t, input logic [15:0] z);
        return {3'b0, s, a, 6'b0, t, z};
    endfunction

    task automatic chk(input int d, input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (!ok) begin
            n_fail++;
            $display("FAIL dut%0d %s: got 0x%08h, expected 0x%08h (t=%0t)", d, name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            busy[d] = 0; gr[d] = 0; last[d] = INPUTS - 1; wcnt[d] = 0; pend[d] = 0;
            pend_tag[d] = 0; pend_data[d] = '0;
        end
    endtask

    task automatic clear_logs();
        for (int d = 0; d < NDUT; d++) begin
            nlog[d] = 0; first_ack[d] = '0;
        end
    endtask

    task automatic check_dut(input int d);
        bit         free_edge;
        logic [3:0] hs;
        int         hs_i;
        int         g;
        free_edge = !busy[d];
        hs        = cap_ack[d] & cap_stb[d];
        hs_i      = -1;

        // Output transfer at the last edge
        if (cap_ozstb[d] && cap_ozack[d]) begin
            chk(d, pend[d] && cap_oz[d] == pend_data[d] && int'(cap_tag[d]) == pend_tag[d],
                "delivered word", pack(cap_ozstb[d], 4'd0, cap_tag[d], cap_oz[d]),
                pack(pend[d], 4'd0, 2'(pend_tag[d]), pend_data[d]));
            if (nlog[d] < LOGSZ) begin
                log_tag[d][nlog[d]]  = int'(cap_tag[d]);
                log_data[d][nlog[d]] = cap_oz[d];
                log_cyc[d][nlog[d]]  = cyc;
            end
            nlog[d]++;
            pend[d] = 0;
            wcnt[d]++;
            if (wcnt[d] < max_burst(d) && (((cap_stb[d] >> gr[d]) & 4'd1) != 4'd0)) begin
                chk(d, inputs_ack[d] == 4'(1 << gr[d]), "burst continuation ack",
                    32'(inputs_ack[d]), 32'(1 << gr[d]));
            end else begin
                last[d] = gr[d]; wcnt[d] = 0; busy[d] = 0;
                chk(d, inputs_ack[d] == 4'd0, "ack after grant release", 32'(inputs_ack[d]), 32'd0);
            end
        end else if (cap_ozstb[d] && !cap_ozack[d]) begin
            chk(d, output_z_stb[d] && output_z[d] == cap_oz[d] && output_z_tag[d] == cap_tag[d]
                && inputs_ack[d] == 4'd0, "stalled output held",
                pack(output_z_stb[d], inputs_ack[d], output_z_tag[d], output_z[d]),
                pack(1'b1, 4'd0, cap_tag[d], cap_oz[d]));
        end

        // Input transfer at the last edge
        if (hs != 4'd0) begin
            for (int i = 0; i < INPUTS; i++) begin
                if (((hs >> i) & 4'd1) != 4'd0) hs_i = i;
            end
            chk(d, busy[d] && hs_i == gr[d], "input transfer source", 32'(hs_i), 32'(gr[d]));
            pend[d]      = 1;
            pend_tag[d]  = hs_i;
            pend_data[d] = cap_in[d][hs_i*WIDTH +: WIDTH];
            remaining[d][hs_i] = remaining[d][hs_i] - 1;
            sdata[d][hs_i]     = sdata[d][hs_i] + 16'h0010;
            chk(d, output_z[d] == pend_data[d] && int'(output_z_tag[d]) == hs_i && inputs_ack[d] == 4'd0,
                "captured word", pack(output_z_stb[d], inputs_ack[d], output_z_tag[d], output_z[d]),
                pack(1'b1, 4'd0, 2'(hs_i), pend_data[d]));
        end

        // Arbitration
        if (free_edge) begin
            if (cap_stb[d] != 4'd0) begin
                g = pick(cap_stb[d], last[d]);
                chk(d, inputs_ack[d] == 4'(1 << g), "round-robin grant", 32'(inputs_ack[d]), 32'(1 << g));
                busy[d] = 1;
                gr[d]   = g;
                if (first_ack[d] == 4'd0) first_ack[d] = inputs_ack[d];
            end else begin
                chk(d, inputs_ack[d] == 4'd0, "idle no ack", 32'(inputs_ack[d]), 32'd0);
            end
        end else if (cap_ack[d] != 4'd0 && hs == 4'd0) begin
            chk(d, inputs_ack[d] == cap_ack[d], "ack held until strobe", 32'(inputs_ack[d]), 32'(cap_ack[d]));
        end

        chk(d, output_z_stb[d] == pend[d], "output valid vs pending word", 32'(output_z_stb[d]), 32'(pend[d]));
        chk(d, $onehot0(inputs_ack[d]), "ack at most one hot", 32'(inputs_ack[d]), 32'd0);
    endtask

    task automatic drive();
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < INPUTS; i++) begin
                inputs_stb[d][i]           = (remaining[d][i] > 0);
                inputs[d][i*WIDTH +: WIDTH] = sdata[d][i];
            end
            output_z_ack[d] = ack_en;
        end
    endtask

    task automatic capture();
        for (int d = 0; d < NDUT; d++) begin
            cap_ack[d]   = inputs_ack[d];
            cap_stb[d]   = inputs_stb[d];
            cap_in[d]    = inputs[d];
            cap_ozstb[d] = output_z_stb[d];
            cap_ozack[d] = output_z_ack[d];
            cap_oz[d]    = output_z[d];
            cap_tag[d]   = output_z_tag[d];
        end
    endtask

    // One cycle: judge the last posedge, then drive and capture for the next
    task automatic step();
        @(negedge clk);
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            for (int d = 0; d < NDUT; d++) check_dut(d);
        end
        drive();
        capture();
    endtask

    task automatic clear_sources();
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < INPUTS; i++) remaining[d][i] = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_assert = 0; n_fail = 0; cyc = 0;
        clear_logs();
        model_reset();
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < INPUTS; i++) begin
                remaining[d][i] = 0;
                sdata[d][i]     = '0;
            end
        end

        // ---- Reset applied mid-cycle with random inputs, no clock edge ----
        rst    = 1'b0;
        ack_en = 1'($urandom_range(0, 1));
        for (int d = 0; d < NDUT; d++) begin
            inputs[d]       = {$urandom, $urandom};
            inputs_stb[d]   = 4'($urandom);
            output_z_ack[d] = ack_en;
        end
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            chk(d, pack(output_z_stb[d], inputs_ack[d], output_z_tag[d], output_z[d]) == 32'd0,
                "async reset values", pack(output_z_stb[d], inputs_ack[d], output_z_tag[d], output_z[d]), 32'd0);
        end
        ack_en = 1'b1;
        capture();
        step(); step(); step();
        rst = 1'b0;

        // ---- Single requester: source 2, data 0x1234 ----
        clear_logs();
        for (int d = 0; d < NDUT; d++) begin
            remaining[d][2] = 1; sdata[d][2] = 16'h1234;
        end
        for (int n = 0; n < 10; n++) step();
        for (int d = 0; d < NDUT; d++) begin
            chk(d, nlog[d] == 1, "single requester word count", 32'(nlog[d]), 32'd1);
            chk(d, log_tag[d][0] == 2 && log_data[d][0] == 16'h1234, "single requester word",
                {14'd0, 2'(log_tag[d][0]), log_data[d][0]}, {14'd0, 2'd2, 16'h1234});
            chk(d, first_ack[d] == 4'b0100, "single requester ack", 32'(first_ack[d]), 32'h4);
        end

        // ---- Fairness (dut0, MAX_BURST=1) and bursts (dut1, MAX_BURST=2) ----
        do_reset();
        clear_logs();
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < INPUTS; i++) begin
                remaining[d][i] = 1000; sdata[d][i] = 16'hA000 + 16'(i);
            end
        end
        begin
            int budget;
            budget = 0;
            while ((nlog[0] < 6 || nlog[1] < 8) && budget < 60) begin
                step(); budget++;
            end
            chk(0, budget < 60, "fairness run completed", 32'(budget), 32'd60);
        end
        begin
            int exp_rr [6];
            int exp_bu [8];
            exp_rr = '{0, 1, 2, 3, 0, 1};
            exp_bu = '{0, 0, 1, 1, 2, 2, 3, 3};
            for (int k = 0; k < 6; k++) begin
                chk(0, log_tag[0][k] == exp_rr[k], "round-robin tag order", 32'(log_tag[0][k]), 32'(exp_rr[k]));
                if (k > 0)
                    chk(0, log_cyc[0][k] - log_cyc[0][k-1] == 3, "round-robin word spacing",
                        32'(log_cyc[0][k] - log_cyc[0][k-1]), 32'd3);
            end
            chk(0, log_data[0][4] == 16'hA010, "second word of source 0", 32'(log_data[0][4]), 32'hA010);
            for (int k = 0; k < 8; k++) begin
                chk(1, log_tag[1][k] == exp_bu[k], "burst tag order", 32'(log_tag[1][k]), 32'(exp_bu[k]));
                if (k > 0)
                    chk(1, log_cyc[1][k] - log_cyc[1][k-1] == ((k % 2 == 1) ? 2 : 3), "burst word spacing",
                        32'(log_cyc[1][k] - log_cyc[1][k-1]), (k % 2 == 1) ? 32'd2 : 32'd3);
            end
            chk(1, log_data[1][1] == 16'hA010 && log_data[1][2] == 16'hA001, "burst word data",
                {log_data[1][1], log_data[1][2]}, {16'hA010, 16'hA001});
        end

        // ---- Backpressure: 0x00FF pending while output_z_ack is low ----
        clear_sources();
        do_reset();
        clear_logs();
        ack_en = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            remaining[d][1] = 1; sdata[d][1] = 16'h00FF;
        end
        begin
            int budget;
            budget = 0;
            while (!(output_z_stb[0] && output_z_stb[1]) && budget < 10) begin
                step(); budget++;
            end
            chk(0, budget < 10, "backpressure word reached output", 32'(budget), 32'd10);
        end
        for (int d = 0; d < NDUT; d++) begin
            remaining[d][2] = 1; sdata[d][2] = 16'h0BBB;
        end
        for (int n = 0; n < 10; n++) begin
            step();
            for (int d = 0; d < NDUT; d++)
                chk(d, output_z_stb[d] && output_z[d] == 16'h00FF && inputs_ack[d] == 4'd0,
                    "backpressure hold", pack(output_z_stb[d], inputs_ack[d], output_z_tag[d], output_z[d]),
                    pack(1'b1, 4'd0, 2'd1, 16'h00FF));
        end
        ack_en = 1'b1;
        step();
        step();
        for (int d = 0; d < NDUT; d++)
            chk(d, nlog[d] == 1 && log_data[d][0] == 16'h00FF && log_cyc[d][0] == cyc,
                "delivered on ack edge", {8'(nlog[d]), 8'(cyc - log_cyc[d][0]), log_data[d][0]},
                {8'd1, 8'd0, 16'h00FF});
        for (int n = 0; n < 8; n++) step();
        for (int d = 0; d < NDUT; d++)
            chk(d, nlog[d] == 2 && log_tag[d][1] == 2, "waiting source served after stall",
                {16'(nlog[d]), 16'(log_tag[d][1])}, {16'd2, 16'd2});

        // ---- Reset during SEND from source 3 ----
        clear_sources();
        do_reset();
        clear_logs();
        ack_en = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            remaining[d][3] = 1; sdata[d][3] = 16'h3333;
        end
        begin
            int budget;
            budget = 0;
            while (!(output_z_stb[0] && output_z_stb[1] && output_z_tag[0] == 2'd3) && budget < 10) begin
                step(); budget++;
            end
            chk(0, budget < 10, "source 3 word reached output", 32'(budget), 32'd10);
        end
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < NDUT; d++)
            chk(d, pack(output_z_stb[d], inputs_ack[d], output_z_tag[d], output_z[d]) == 32'd0,
                "reset during send", pack(output_z_stb[d], inputs_ack[d], output_z_tag[d], output_z[d]), 32'd0);
        for (int d = 0; d < NDUT; d++) begin
            remaining[d][1] = 1; sdata[d][1] = 16'h1111;
            remaining[d][3] = 1; sdata[d][3] = 16'h3333;
        end
        step(); step();
        rst    = 1'b0;
        ack_en = 1'b1;
        begin
            int budget;
            budget = 0;
            while ((nlog[0] < 2 || nlog[1] < 2) && budget < 20) begin
                step(); budget++;
            end
            chk(0, budget < 20, "post-reset words delivered", 32'(budget), 32'd20);
        end
        for (int d = 0; d < NDUT; d++)
            chk(d, log_tag[d][0] == 1 && log_data[d][0] == 16'h1111 && log_tag[d][1] == 3,
                "pointer restored after reset", {8'(log_tag[d][0]), 8'(log_tag[d][1]), log_data[d][0]},
                {8'd1, 8'd3, 16'h1111});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_round_robin_arbiter.md
Name: stream_round_robin_arbiter

Overview:
- Shares one 16-bit stb/ack output stream between INPUTS requesting stream sources. Replaces a fixed poll order with a fair round-robin selection.
- Supports optional bounded bursts per grant.
- Each delivered word carries a tag identifying its source.
- Sits between C-process producers and a single shared consumer (e.g. a UART or output FIFO).

Parameters:
- WIDTH, 16, data width of every input and the output.
- INPUTS, 4, number of requesters (2..16).
- TAG_WIDTH, 2, width of the source tag; must be >= clog2(INPUTS).
- MAX_BURST, 1, maximum consecutive words accepted from one winner before priority moves on (1..255).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- inputs  in  INPUTS*WIDTH  packed source data; source i occupies bits [i*WIDTH +: WIDTH].
- inputs_stb  in  INPUTS  per-source valid; the source holds it and its data stable until acked.
- inputs_ack  out  INPUTS  per-source accept, registered, at most one bit high.
- output_z  out  WIDTH  arbitrated data, registered.
- output_z_tag  out  TAG_WIDTH  index of the source that produced output_z.
- output_z_stb  out  1  output valid.
- output_z_ack  in  1  consumer accept.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values (applied immediately on rst, independent of clk):
  - inputs_ack=0, output_z_stb=0, output_z=0, output_z_tag=0.
  - state=IDLE, grant=0, last_grant=INPUTS-1 (source 0 has first priority), burst_cnt=0.
- Handshake rule: a transfer occurs on a rising edge where stb and ack are both high.
- State IDLE:
  - Search indices last_grant+1 .. last_grant+INPUTS (mod INPUTS). Pick the first i with inputs_stb[i]=1.
  - If found: grant<=i, inputs_ack[i]<=1, go to ACCEPT. If none: stay in IDLE.
- State ACCEPT:
  - inputs_ack[grant] stays high until inputs_stb[grant]=1 at an edge.
  - On that edge: output_z<=inputs[grant], output_z_tag<=grant, inputs_ack<=0, output_z_stb<=1, go to SEND.
- State SEND:
  - output_z_stb, output_z and output_z_tag are held stable until output_z_ack=1 at an edge.
  - On that edge output_z_stb<=0, then:
    - If burst_cnt+1 < MAX_BURST and inputs_stb[grant]=1: burst_cnt++, inputs_ack[grant]<=1, go to ACCEPT (same source, no re-arbitration).
    - Otherwise: last_grant<=grant, burst_cnt<=0, go to IDLE.
- Latency:
  - Request seen in IDLE to inputs_ack high: 1 cycle.
  - Input handshake to output_z_stb high: 1 cycle.
  - Throughput: 3 cycles/word across arbitration, 2 cycles/word inside a burst (output_z_ack held high).
- Boundary conditions:
  - A request arriving in the same cycle as IDLE evaluation is seen that cycle.
  - Requests from non-granted sources never get ack; their stb and data are not consumed.
  - If the granted source drops stb in ACCEPT (protocol violation), the arbiter waits indefinitely; there is no timeout.
  - Backpressure: while output_z_ack is low, no inputs_ack is asserted.
  - Pointer wrap: last_grant=INPUTS-1 searches from 0.
  - A single requester is re-granted every round.
  - MAX_BURST=1 gives pure round robin.
  - Reset mid-operation: any in-flight word is discarded. Sources whose ack was pending must keep stb high and are re-arbitrated after reset.

Decomposition:
- Package stream_arbiter_pkg holds:
  - state encoding constants IDLE=2'd0, ACCEPT=2'd1, SEND=2'd2;
  - a clog2 helper function.
- One combinational sub-module, rr_pick: inputs request vector and last_grant; outputs found flag and winning index. It rotates, priority-encodes and un-rotates.
- The FSM, burst counter and registers stay in the top module.

Test Plan:
- Reset: drive rst=1 mid-cycle with random inputs. Required: inputs_ack=0, output_z_stb=0, output_z=0, output_z_tag=0 immediately, without a clock edge.
- Single requester: only source 2 with inputs_stb[2]=1, data 0x1234, output_z_ack=1. Required: inputs_ack=4'b0100 for one handshake, then output_z=0x1234, output_z_tag=2. Exactly one word delivered.
- Fairness (MAX_BURST=1): all four stb held high, source data 0xA000+i, output_z_ack=1. Required: tags in order 0,1,2,3,0,1 and 3 cycles per word.
- Bursts (MAX_BURST=2): all four sources requesting. Required: tags 0,0,1,1,2,2,3,3, and 2 cycles between words inside each pair.
- Backpressure: hold output_z_ack=0 for 10 cycles with word 0x00FF pending. Required: output_z_stb stays high, output_z stays 0x00FF, inputs_ack stays 0. Word delivered on the edge where ack rises.
- Reset during SEND from source 3. Required: output_z_stb drops asynchronously. After release with sources 1 and 3 requesting, source 1 wins first (pointer back to INPUTS-1).
